// File: rtl/letter_pkg.sv
// Shared types for the letter transmit queue.
// Letter encoding and transmit-pacing FSM states.
package letter_pkg;

    localparam int LETTER_W   = 5;
    localparam int LETTER_MAX = 25;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_HI,
        WAIT_LO
    } tx_q_state_t;

endpackage

// File: rtl/letter_queue_ram.sv
// Simple dual-port letter storage, one clock.
// Registered read port returns the pre-write word on a same-address collision.
module letter_queue_ram #(
    parameter  int DW    = 5,
    parameter  int DEPTH = 1024,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port, one-cycle latency.
    always_ff @(posedge clk_in) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/letter_tx_queue.sv
// Elastic letter queue feeding the IR transmitter.
// Paces issue on the transmitter busy handshake plus an idle gap.
module letter_tx_queue
    import letter_pkg::*;
#(
    parameter  int DATA_WIDTH   = LETTER_W,
    parameter  int DEPTH        = 1024,
    parameter  int GAP_CYCLES   = 100000,
    parameter  int BUSY_TIMEOUT = 1000,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_in,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  tx_busy_in,
    output logic                  data_valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CW-1:0]         count_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic                  timeout_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

    tx_q_state_t state, state_nx;

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [GW-1:0]         gap;
    logic [TW-1:0]         tcnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full, empty;
    logic                  push, pop, drop;
    logic                  gap_load, to_hit;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign pop  = (state == IDLE) && !empty && !tx_busy_in
                  && (gap == '0) && !flush_in;
    assign push = data_valid_in && !flush_in && (!full || pop);
    assign drop = data_valid_in && !flush_in && !push;

    letter_queue_ram #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    // Issue FSM next state, gap reload and timeout detection.
    always_comb begin
        state_nx = state;
        gap_load = 1'b0;
        to_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) state_nx = READ;
            end
            READ: begin
                state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy_in) begin
                    state_nx = WAIT_LO;
                end else if (tcnt == TO_LAST) begin
                    to_hit   = 1'b1;
                    gap_load = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy_in) begin
                    gap_load = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush_in) begin
            state_nx = IDLE;
            gap_load = 1'b0;
            to_hit   = 1'b0;
        end
    end

    // Inter-letter gap and busy-rise timeout counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gap  <= '0;
            tcnt <= '0;
        end else begin
            if (flush_in)        gap <= '0;
            else if (gap_load)   gap <= GAP_LOAD;
            else if (gap != '0)  gap <= gap - GW'(1);
            if (flush_in || state == READ) tcnt <= '0;
            else if (state == WAIT_HI)     tcnt <= tcnt + TW'(1);
        end
    end

    // Issue strobe and held letter towards the transmitter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_valid_out <= 1'b0;
            data_out       <= '0;
        end else begin
            data_valid_out <= (state == READ) && !flush_in;
            if (state == READ && !flush_in) data_out <= rd_data;
        end
    end

    // Sticky overflow and timeout status.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overflow_out <= 1'b0;
            timeout_out  <= 1'b0;
        end else if (flush_in) begin
            overflow_out <= 1'b0;
            timeout_out  <= 1'b0;
        end else begin
            if (drop)   overflow_out <= 1'b1;
            if (to_hit) timeout_out  <= 1'b1;
        end
    end

    assign count_out = count;
    assign full_out  = full;
    assign empty_out = empty;

endmodule

// File: doc/letter_tx_queue.md
Name: letter_tx_queue

Overview:
- Elastic letter queue between the enigma encoder output and ir_transmitter. Replaces the ad-hoc BRAM pointer logic in top level.
- Accepts one 5-bit letter per data_valid_in pulse and stores it in order.
- Issues letters one at a time to ir_transmitter. Paces issue by the transmitter's busy handshake plus a programmable inter-letter gap.
- Reports occupancy, sticky overflow and handshake-timeout status for LED and seven-segment debug.

Parameters:
- DATA_WIDTH, 5, letter width (0-25 = A-Z).
- DEPTH, 1024, queue entries; any value ≥2; pointers wrap at DEPTH-1.
- GAP_CYCLES, 100000, idle cycles after busy falls before the next issue (1 ms at 100 MHz); 0 allowed.
- BUSY_TIMEOUT, 1000, cycles to wait for tx_busy_in to rise after an issue.

Ports:
- clk_in  in  1  system clock (clk_100_passthrough domain)
- rst_in  in  1  asynchronous, active-low reset
- flush_in  in  1  synchronous clear of queue contents and status
- data_valid_in  in  1  one-cycle push strobe from encoder
- data_in  in  DATA_WIDTH  letter to push
- tx_busy_in  in  1  ir_transmitter busy_out
- data_valid_out  out  1  one-cycle issue strobe to ir_transmitter
- data_out  out  DATA_WIDTH  letter being issued; held until next issue
- count_out  out  $clog2(DEPTH+1)  current occupancy
- full_out  out  1  count_out == DEPTH
- empty_out  out  1  count_out == 0
- overflow_out  out  1  sticky: a push was dropped
- timeout_out  out  1  sticky: busy never rose after an issue

Behaviour:
- Reset (rst_in low, async): wr_ptr = rd_ptr = count = 0; state IDLE; gap counter 0. All outputs 0 except empty_out = 1. RAM contents undefined.
- Push: accepted iff data_valid_in && (!full || pop this cycle). Accepted push writes RAM[wr_ptr] and advances wr_ptr with wrap DEPTH-1 → 0. Rejected push sets overflow_out; queue unchanged.
- Occupancy: count <= count + push − pop. Simultaneous push and pop leaves count unchanged.
- Pop requires registered count > 0. A push into an empty queue is never popped in the same cycle, so there is no read-during-write hazard.
- FSM states:
  - IDLE: if count > 0 && !tx_busy_in && gap == 0 → pop (rd_ptr++ with wrap, RAM read of old rd_ptr), go to READ.
  - READ: RAM data valid. Register data_out <= RAM data, data_valid_out <= 1, clear timeout counter, go to WAIT_HI.
  - WAIT_HI: data_valid_out back to 0. On tx_busy_in = 1 → WAIT_LO. If the timeout counter reaches BUSY_TIMEOUT−1 → set timeout_out, load gap = GAP_CYCLES, go to IDLE.
  - WAIT_LO: on tx_busy_in = 0 → load gap = GAP_CYCLES, go to IDLE.
- Gap counter decrements to 0 in any state; IDLE gating uses gap == 0.
- Latency: push at edge k into empty queue, idle, gap 0, not busy → data_valid_out high in the cycle after edge k+2 (2-cycle latency).
- data_valid_out: exactly one cycle per popped letter. Never asserted while tx_busy_in was high in the preceding IDLE cycle.
- flush_in (sync): pointers, count, overflow_out and timeout_out cleared; state forced to IDLE; gap cleared.
  - A letter already in flight in ir_transmitter completes, because IDLE still waits for !tx_busy_in.
  - flush_in has priority over a same-cycle push (push dropped, overflow not set).
- Reset mid-transmission: queue empties immediately; data_valid_out forced 0.
- Counts and pointers are unsigned. Wrap compare is against DEPTH-1, not a power-of-2 mask.

Decomposition:
- Package letter_pkg: LETTER_W = 5, LETTER_MAX = 25, FSM enum tx_q_state_t {IDLE, READ, WAIT_HI, WAIT_LO}.
- Sub-module letter_queue_ram: simple dual-port, one clock, one write port, one registered read port (1-cycle latency), inferred as BRAM.
- All control logic lives in letter_tx_queue.

Test Plan:
- Push 'C' (2) into empty queue, tx_busy_in low, GAP_CYCLES = 0 → data_valid_out pulse 2 cycles later with data_out = 2; count returns to 0.
- Push 5 letters back-to-back (0,1,2,3,4); model busy high 20 cycles after each issue, GAP_CYCLES = 10 → five issues in order, each ≥ 31 cycles apart, exactly one pulse each.
- DEPTH = 4: push 6 letters while tx_busy_in held high → full_out = 1, count 4, overflow_out = 1. Release busy → letters 0-3 issued, 4 and 5 absent.
- Full queue with push and pop in the same cycle → push accepted, count stays 4, overflow_out stays 0, wrap ordering preserved across pointer wrap.
- Busy never rises after issue, BUSY_TIMEOUT = 50 → timeout_out set at cycle 50 after the pulse; next letter still issued after the gap.
- Assert flush_in with 3 queued while busy high, then assert rst_in low mid-WAIT_LO → after flush: count 0, no further issues. After reset: all outputs at reset values, empty_out = 1.
